// File: rtl/store_lane_unit.sv
// store_lane_unit
//
// Purpose: narrows a 32-bit register value to byte, halfword or word width
// and places it on the little-endian byte lanes of the data-memory write
// port. Byte offset k maps to lane k and o_mem_be[k]. A store that crosses
// a word boundary is issued as two word-aligned write beats under a
// request/acknowledge handshake.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   i_valid      store request present
//   o_ready      unit idle; a request is accepted when i_valid & o_ready
//   i_addr       byte address of the store
//   i_word       register data (only the low byte/halfword for narrow sizes)
//   i_size       00 byte, 01 halfword, 10 word, 11 illegal
//   o_mem_req    write beat valid
//   i_mem_ack    memory accepted the current beat
//   o_mem_addr   word-aligned beat address
//   o_mem_wdata  lane-placed write data (disabled lanes are zero)
//   o_mem_be     byte enables
//   o_done       one-cycle pulse: store finished
//   o_err        one-cycle pulse: illegal size, nothing written

module store_lane_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_word,
  input  logic [1:0]  i_size,
  output logic        o_mem_req,
  input  logic        i_mem_ack,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_be,
  output logic        o_done,
  output logic        o_err
);

  typedef enum logic [1:0] {
    IDLE,
    BEAT0,
    BEAT1
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [29:0] word_addr_q;
  logic [31:0] data_q;
  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic        done_q;
  logic        err_q;

  logic        capture;
  logic        done_next;
  logic        err_next;
  logic [31:0] narrowed;
  logic [3:0]  size_mask;
  logic [7:0]  lane_mask;
  logic [63:0] lane_data;
  logic        split;
  logic [31:0] beat0_addr;
  logic [31:0] beat1_addr;

  // Narrowing happens at capture so the upper bits are already zero when
  // the data is shifted onto the lanes; disabled lanes then read as 0.
  always_comb begin
    narrowed = i_word;
    case (i_size)
      2'b00:   narrowed = {24'b0, i_word[7:0]};
      2'b01:   narrowed = {16'b0, i_word[15:0]};
      default: narrowed = i_word;
    endcase
  end

  // Lane placement spans two words: the upper half of the 8-bit mask and
  // 64-bit data belongs to the following word and is only non-zero when
  // the store crosses the word boundary.
  always_comb begin
    size_mask = 4'b1111;
    case (size_q)
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
    lane_mask  = {4'b0, size_mask} << off_q;
    lane_data  = {32'b0, data_q} << {off_q, 3'b000};
    split      = |lane_mask[7:4];
    beat0_addr = {word_addr_q, 2'b00};
    beat1_addr = beat0_addr + 32'd4;
  end

  // State, captured request and registered completion pulses. Reset clears
  // everything so an in-flight beat is dropped without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      word_addr_q <= '0;
      data_q      <= '0;
      size_q      <= '0;
      off_q       <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state  <= state_next;
      done_q <= done_next;
      err_q  <= err_next;
      if (capture) begin
        word_addr_q <= i_addr[31:2];
        data_q      <= narrowed;
        size_q      <= i_size;
        off_q       <= i_addr[1:0];
      end
    end
  end

  // Next-state and beat outputs. Beat fields come straight from the held
  // request, so they stay stable for as long as the memory withholds ack.
  always_comb begin
    state_next  = state;
    capture     = 1'b0;
    done_next   = 1'b0;
    err_next    = 1'b0;
    o_mem_req   = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_be    = '0;
    case (state)
      IDLE: begin
        if (i_valid) begin
          capture = 1'b1;
          if (i_size == 2'b11) begin
            done_next = 1'b1;
            err_next  = 1'b1;
          end else begin
            state_next = BEAT0;
          end
        end
      end
      BEAT0: begin
        o_mem_req   = 1'b1;
        o_mem_addr  = beat0_addr;
        o_mem_be    = lane_mask[3:0];
        o_mem_wdata = lane_data[31:0];
        if (i_mem_ack) begin
          if (split) begin
            state_next = BEAT1;
          end else begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end
      BEAT1: begin
        o_mem_req   = 1'b1;
        o_mem_addr  = beat1_addr;
        o_mem_be    = lane_mask[7:4];
        o_mem_wdata = lane_data[63:32];
        if (i_mem_ack) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign o_ready = (state == IDLE) & ~rst;
  assign o_done  = done_q;
  assign o_err   = err_q;

endmodule

// File: tb/tb_store_lane_unit.sv
// tb_store_lane_unit
//
// Purpose: directed self-checking bench for store_lane_unit. Expected write
// beats are queued when a store is driven and popped by a monitor whenever
// the DUT transfers a beat; completion and handshake timing are checked
// inline at fixed cycles.
//
// Ports: none (top-level bench).

module tb_store_lane_unit;

  logic        clk;
  logic        rst;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_addr;
  logic [31:0] i_word;
  logic [1:0]  i_size;
  logic        o_mem_req;
  logic        i_mem_ack;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_be;
  logic        o_done;
  logic        o_err;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } beat_t;

  beat_t exp_q[$];
  int    vectors;
  int    miscompares;

  store_lane_unit dut (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_addr     (i_addr),
    .i_word     (i_word),
    .i_size     (i_size),
    .o_mem_req  (o_mem_req),
    .i_mem_ack  (i_mem_ack),
    .o_mem_addr (o_mem_addr),
    .o_mem_wdata(o_mem_wdata),
    .o_mem_be   (o_mem_be),
    .o_done     (o_done),
    .o_err      (o_err)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts the vector and reports any miscompare.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beat(input logic [31:0] a, input logic [3:0] be,
                           input logic [31:0] d);
    beat_t b;
    b.addr = a;
    b.be   = be;
    b.data = d;
    exp_q.push_back(b);
  endtask

  // Presents one request for a single cycle; returns one cycle after accept.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] w,
                               input logic [1:0] s);
    i_valid = 1'b1;
    i_addr  = a;
    i_word  = w;
    i_size  = s;
    next_cycle();
    i_valid = 1'b0;
  endtask

  // Store with ack tied high: beats back-to-back, done after the last one.
  task automatic run_store(input string tag, input logic [31:0] a,
                           input logic [31:0] w, input logic [1:0] s,
                           input int beats);
    applyStimulus(a, w, s);
    for (int i = 0; i < beats; i++) begin
      checkOutput({tag, "_req"}, {31'b0, o_mem_req}, 32'd1);
      checkOutput({tag, "_done_early"}, {31'b0, o_done}, 32'd0);
      next_cycle();
    end
    checkOutput({tag, "_done"}, {31'b0, o_done}, 32'd1);
    checkOutput({tag, "_err"}, {31'b0, o_err}, 32'd0);
    checkOutput({tag, "_req_off"}, {31'b0, o_mem_req}, 32'd0);
    next_cycle();
    checkOutput({tag, "_done_pulse"}, {31'b0, o_done}, 32'd0);
  endtask

  // Scoreboard monitor: every transferred beat must match the oldest
  // expected beat, and no beat may transfer when none is expected.
  always @(negedge clk) begin
    beat_t b;
    if (!rst && o_mem_req && i_mem_ack) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_beat_addr", o_mem_addr, 32'hxxxxxxxx);
      end else begin
        b = exp_q.pop_front();
        checkOutput("beat_addr", o_mem_addr, b.addr);
        checkOutput("beat_be", {28'b0, o_mem_be}, {28'b0, b.be});
        checkOutput("beat_data", o_mem_wdata, b.data);
      end
    end
  end

  // Directed sequence.
  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    i_valid     = 1'b0;
    i_addr      = '0;
    i_word      = '0;
    i_size      = '0;
    i_mem_ack   = 1'b1;

    // Reset state.
    next_cycle();
    next_cycle();
    checkOutput("rst_req", {31'b0, o_mem_req}, 32'd0);
    checkOutput("rst_addr", o_mem_addr, 32'd0);
    checkOutput("rst_wdata", o_mem_wdata, 32'd0);
    checkOutput("rst_be", {28'b0, o_mem_be}, 32'd0);
    checkOutput("rst_done", {31'b0, o_done}, 32'd0);
    checkOutput("rst_err", {31'b0, o_err}, 32'd0);
    checkOutput("rst_ready", {31'b0, o_ready}, 32'd0);
    rst = 1'b0;
    next_cycle();
    checkOutput("ready_after_rst", {31'b0, o_ready}, 32'd1);

    // Byte store on lane 2.
    push_beat(32'h0000_1000, 4'b0100, 32'h00AB_0000);
    run_store("byte_off2", 32'h0000_1002, 32'hFFFF_FFAB, 2'b00, 1);

    // Halfword at offset 3 splits across two words.
    push_beat(32'h0000_2000, 4'b1000, 32'hEF00_0000);
    push_beat(32'h0000_2004, 4'b0001, 32'h0000_00BE);
    run_store("half_off3", 32'h0000_2003, 32'h1234_BEEF, 2'b01, 2);

    // Word at the top of memory: second beat wraps to address 0.
    push_beat(32'hFFFF_FFFC, 4'b1000, 32'h4400_0000);
    push_beat(32'h0000_0000, 4'b0111, 32'h0011_2233);
    run_store("word_wrap", 32'hFFFF_FFFF, 32'h1122_3344, 2'b10, 2);

    // Halfword at offset 1 stays in one word.
    push_beat(32'h1000_0000, 4'b0110, 32'h0056_7800);
    run_store("half_off1", 32'h1000_0001, 32'hAAAA_5678, 2'b01, 1);

    // Word at offset 2 splits evenly.
    push_beat(32'h2000_0000, 4'b1100, 32'hBABE_0000);
    push_beat(32'h2000_0004, 4'b0011, 32'h0000_CAFE);
    run_store("word_off2", 32'h2000_0002, 32'hCAFE_BABE, 2'b10, 2);

    // Byte at offset 3 is single beat.
    push_beat(32'h0000_0000, 4'b1000, 32'h7800_0000);
    run_store("byte_off3", 32'h0000_0003, 32'h1234_5678, 2'b00, 1);

    // Aligned word with ack withheld for three cycles; a request during
    // the wait must be ignored.
    i_mem_ack = 1'b0;
    push_beat(32'h0000_3000, 4'b1111, 32'h1122_3344);
    applyStimulus(32'h0000_3000, 32'h1122_3344, 2'b10);
    for (int i = 1; i <= 4; i++) begin
      if (i == 2) begin
        i_valid = 1'b1;
        i_addr  = 32'h0000_5000;
        i_word  = 32'h0000_0077;
        i_size  = 2'b00;
      end else begin
        i_valid = 1'b0;
      end
      if (i == 4) i_mem_ack = 1'b1;
      checkOutput("hold_req", {31'b0, o_mem_req}, 32'd1);
      checkOutput("hold_addr", o_mem_addr, 32'h0000_3000);
      checkOutput("hold_be", {28'b0, o_mem_be}, 32'hF);
      checkOutput("hold_data", o_mem_wdata, 32'h1122_3344);
      checkOutput("hold_ready", {31'b0, o_ready}, 32'd0);
      checkOutput("hold_done", {31'b0, o_done}, 32'd0);
      next_cycle();
    end
    i_mem_ack = 1'b0;
    checkOutput("hold_done_pulse", {31'b0, o_done}, 32'd1);
    checkOutput("hold_req_off", {31'b0, o_mem_req}, 32'd0);
    next_cycle();
    checkOutput("ignored_req", {31'b0, o_mem_req}, 32'd0);
    checkOutput("hold_done_clear", {31'b0, o_done}, 32'd0);
    checkOutput("hold_ready_back", {31'b0, o_ready}, 32'd1);
    i_mem_ack = 1'b1;

    // Illegal size: error and done pulse together, no beat.
    applyStimulus(32'h0000_1235, 32'hDEAD_0001, 2'b11);
    checkOutput("illegal_err", {31'b0, o_err}, 32'd1);
    checkOutput("illegal_done", {31'b0, o_done}, 32'd1);
    checkOutput("illegal_req", {31'b0, o_mem_req}, 32'd0);
    next_cycle();
    checkOutput("illegal_err_clear", {31'b0, o_err}, 32'd0);
    checkOutput("illegal_done_clear", {31'b0, o_done}, 32'd0);
    checkOutput("illegal_req_late", {31'b0, o_mem_req}, 32'd0);

    // Split word, reset during BEAT1 with ack low.
    push_beat(32'h4000_0000, 4'b1110, 32'hADBE_EF00);
    applyStimulus(32'h4000_0001, 32'hDEAD_BEEF, 2'b10);
    next_cycle();
    i_mem_ack = 1'b0;
    checkOutput("b1_req", {31'b0, o_mem_req}, 32'd1);
    checkOutput("b1_addr", o_mem_addr, 32'h4000_0004);
    checkOutput("b1_be", {28'b0, o_mem_be}, 32'h1);
    checkOutput("b1_data", o_mem_wdata, 32'h0000_00DE);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    checkOutput("midrst_req", {31'b0, o_mem_req}, 32'd0);
    checkOutput("midrst_done", {31'b0, o_done}, 32'd0);
    checkOutput("midrst_be", {28'b0, o_mem_be}, 32'd0);
    next_cycle();
    checkOutput("midrst_ready", {31'b0, o_ready}, 32'd1);
    checkOutput("midrst_no_done", {31'b0, o_done}, 32'd0);
    checkOutput("midrst_req_idle", {31'b0, o_mem_req}, 32'd0);
    i_mem_ack = 1'b1;
    next_cycle();

    checkOutput("queue_empty", exp_q.size(), 32'd0);

    $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/store_lane_unit.md
# store_lane_unit

Store-side counterpart to the load/immediate extension path: narrows a 32-bit register value to byte, halfword or word width and places it on the correct byte lanes of the data-memory write port. Sits between the datapath store operands (address, rs/rt data, size from control) and the data memory. Misaligned stores that cross a word boundary are split into two word-aligned write beats under a request/acknowledge handshake. Byte lanes are little-endian: byte offset k maps to lane k and `o_mem_be[k]`.

## Interface
- No parameters. Address and data widths are fixed at 32 bits.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous active-high reset
- `i_valid`  in  1  store request present
- `o_ready`  out  1  unit idle, request accepted when `i_valid & o_ready`
- `i_addr`  in  32  byte address of the store
- `i_word`  in  32  register data; only the low byte or halfword is used for narrow sizes
- `i_size`  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- `o_mem_req`  out  1  write beat valid
- `i_mem_ack`  in  1  memory accepted current beat
- `o_mem_addr`  out  32  word-aligned beat address, `[1:0]` always 00
- `o_mem_wdata`  out  32  lane-placed write data
- `o_mem_be`  out  4  byte enables
- `o_done`  out  1  one-cycle pulse: store finished
- `o_err`  out  1  one-cycle pulse: illegal size, no memory write

## Operation
- Clock and reset: one clock (`clk`); `rst` is synchronous and active-high.
- States: IDLE, BEAT0, BEAT1.
- Request capture (IDLE, `i_valid` high): the unit registers `addr`, `word`, `size` and offset `off = i_addr[1:0]`.
- `o_ready = (state == IDLE) & ~rst`. Requests are not captured in any other state.
- Size mask `SM`: byte 0001, half 0011, word 1111. 8-bit mask `M = {4'b0,SM} << off`. 64-bit data `D = {32'b0, narrowed word} << (8*off)`.
  - The narrowed word zeroes the bits above the selected size.
- BEAT0:
  - `o_mem_addr = {addr[31:2],2'b00}`, `o_mem_be = M[3:0]`, `o_mem_wdata = D[31:0]`.
- BEAT1 is entered only when `M[7:4] != 0`:
  - `o_mem_addr = {addr[31:2],2'b00} + 4`, 32-bit wrap (0xFFFFFFFC+4 = 0x00000000).
  - `o_mem_be = M[7:4]`, `o_mem_wdata = D[63:32]`.
- Transitions:
  - IDLE → BEAT0 on accept with a legal size.
  - BEAT0 → BEAT1 on ack when split is needed, else → IDLE.
  - BEAT1 → IDLE on ack.
- Illegal size (11): the request is accepted, the state stays IDLE, and no beat is issued. `o_err` and `o_done` pulse together the next cycle.
- `o_mem_wdata` lanes with `be = 0` are driven 0.

## Timing
- Reset values: state IDLE; `o_mem_req`, `o_mem_addr`, `o_mem_wdata`, `o_mem_be`, `o_done`, `o_err` all 0. `o_ready` is 0 while `rst` is high and 1 the cycle after.
- Handshake:
  - A beat transfers on the cycle where `o_mem_req & i_mem_ack` are both high.
  - While `o_mem_req` is high and ack is low, addr, data and be are held stable.
  - An ack while `o_mem_req` is low is ignored.
- Back-to-back beats: after a BEAT0 ack with split needed, `o_mem_req` stays high the next cycle with the BEAT1 values. There is no bubble.
- Latency with ack tied high: accept at cycle 0, BEAT0 at cycle 1. For an aligned store `o_done` pulses at cycle 2; for a split store BEAT1 is at cycle 2 and `o_done` at cycle 3.
- `o_done` is registered, asserted the cycle after the final ack. In that same cycle the state is IDLE, so a new request may be accepted while `o_done` is high.
- Reset mid-operation: all outputs are 0 on the next edge. The beat in flight is abandoned, no `o_done` is produced, and `o_ready` returns after `rst` deasserts.
- Halfword at off 3 and word at off 1..3 split. All other legal combinations are single beat.

## Test plan
- Byte store, addr 0x00001002, word 0xFFFFFFAB, ack tied high → one beat: addr 0x00001000, be 0100, data 0x00AB0000. `o_done` at cycle 2, no `o_err`.
- Halfword store, addr 0x00002003, word 0x1234BEEF → BEAT0: addr 0x00002000, be 1000, data 0xEF000000. BEAT1: addr 0x00002004, be 0001, data 0x000000BE. `o_done` at cycle 3.
- Word store, addr 0xFFFFFFFF, word 0x11223344 → BEAT0: addr 0xFFFFFFFC, be 1000, data 0x44000000. BEAT1: addr 0x00000000, be 0111, data 0x00112233 (wrap).
- Aligned word, addr 0x00003000, ack held low 3 cycles → `o_mem_req`, addr, be 1111 and data 0x11223344 are stable for 4 cycles. `o_ready` stays low and an `i_valid` pulse during the wait is ignored. `o_done` pulses 1 cycle after the ack.
- `i_size` 11 at any address → `o_mem_req` never rises. `o_err` and `o_done` are both 1 for exactly one cycle at cycle 1.
- Split word store, `rst` asserted during BEAT1 with ack low → `o_mem_req` is 0 next cycle, `o_done` never pulses, and `o_ready` is 1 the cycle after `rst` drops.
